// File: rtl/ram_io_responder.sv
// Byte-wide RAM plus memory-mapped I/O window (TX FIFO, RX holding register, status, halt).
// Latency: reads return one cycle after the address is presented; writes land on the same edge.
// Backpressure: out_io_full warns at occupancy >= TX_DEPTH-2; rdy=0 freezes all state.
module ram_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_rw,
  input  logic [31:0] in_addr,
  input  logic [7:0]  in_data,
  output logic [7:0]  out_data,
  output logic        out_io_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        out_halt
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int PTR_W = TX_AW + 1;
  localparam logic [PTR_W-1:0] DEPTH_CNT  = PTR_W'(TX_DEPTH);
  localparam logic [PTR_W-1:0] NEAR_FULL  = PTR_W'(TX_DEPTH - 2);

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  // Storage
  logic [7:0] mem    [2**RAM_ADDR_WIDTH];
  logic [7:0] tx_mem [TX_DEPTH];

  // TX FIFO pointers carry one extra wrap bit so full and empty are distinct.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] occ;

  logic       ovf;
  logic       rx_full;
  logic [7:0] rx_hold;

  // Decode
  logic                      io_sel;
  logic [2:0]                io_off;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      ram_wr;
  logic                      io_data_wr;
  logic                      io_data_rd;
  logic                      io_status_wr;

  logic       tx_empty;
  logic       tx_full;
  logic       tx_pop;
  logic       tx_push_req;
  logic       tx_push_ok;
  logic       tx_drop;
  logic       rx_capture;
  logic       rx_clear;
  logic [7:0] status;
  logic [7:0] io_rd_data;

  // Only some address bits are decoded; upper bits alias by design.
  logic addr_unused;
  assign addr_unused = ^in_addr;

  // Address decode and access qualification (everything gated by rdy).
  always_comb begin
    io_sel       = (in_addr[17:16] == 2'b11);
    io_off       = in_addr[2:0];
    ram_idx      = in_addr[RAM_ADDR_WIDTH-1:0];
    ram_wr       = rdy && !io_sel && in_rw;
    io_data_wr   = rdy && io_sel && in_rw && (io_off == OFF_DATA);
    io_data_rd   = rdy && io_sel && !in_rw && (io_off == OFF_DATA);
    io_status_wr = rdy && io_sel && in_rw && (io_off == OFF_STATUS);
  end

  // FIFO flags and push/pop decisions; a pop frees the slot for a push while full.
  always_comb begin
    occ         = wr_ptr - rd_ptr;
    tx_empty    = (wr_ptr == rd_ptr);
    tx_full     = (occ == DEPTH_CNT);
    tx_pop      = rdy && !tx_empty && tx_ready;
    tx_push_req = io_data_wr;
    tx_push_ok  = tx_push_req && (!tx_full || tx_pop);
    tx_drop     = tx_push_req && tx_full && !tx_pop;
  end

  assign tx_valid    = !tx_empty;
  assign tx_data     = tx_mem[rd_ptr[TX_AW-1:0]];
  assign out_io_full = (occ >= NEAR_FULL);
  assign rx_ready    = !rx_full;

  // RX capture only happens into an empty register; a read-clear of an empty register is a no-op.
  always_comb begin
    rx_capture = rdy && rx_valid && !rx_full;
    rx_clear   = io_data_rd && rx_full;
  end

  // I/O read mux: unmapped offsets read as zero.
  always_comb begin
    status     = {5'b0, ovf, rx_full, tx_full};
    io_rd_data = 8'h00;
    case (io_off)
      OFF_DATA:   io_rd_data = rx_full ? rx_hold : 8'h00;
      OFF_STATUS: io_rd_data = status;
      default:    io_rd_data = 8'h00;
    endcase
  end

  // RAM array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && ram_wr) begin
      mem[ram_idx] <= in_data;
    end
  end

  // TX FIFO storage write; contents are discarded logically via pointer reset.
  always_ff @(posedge clk) begin
    if (!rst && tx_push_ok) begin
      tx_mem[wr_ptr[TX_AW-1:0]] <= in_data;
    end
  end

  // Registered read data; writes and stalled cycles leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= 8'h00;
    end else if (rdy && !in_rw) begin
      out_data <= io_sel ? io_rd_data : mem[ram_idx];
    end
  end

  // TX FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (tx_push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)     rd_ptr <= rd_ptr + 1'b1;
      if (tx_drop)    ovf    <= 1'b1;
    end
  end

  // RX holding register; a capture takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_full <= 1'b0;
      rx_hold <= 8'h00;
    end else if (rx_capture) begin
      rx_full <= 1'b1;
      rx_hold <= rx_data;
    end else if (rx_clear) begin
      rx_full <= 1'b0;
    end
  end

  // Sticky halt request, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_halt <= 1'b0;
    end else if (io_status_wr) begin
      out_halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: directed scenarios then randomized traffic.
// Reference model uses an associative byte array, a byte queue for TX and plain flags.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_ram_io_responder;

  localparam int RAW = 17;
  localparam int TXD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        in_rw = 1'b0;
  logic [31:0] in_addr = 32'h0;
  logic [7:0]  in_data = 8'h0;
  logic [7:0]  out_data;
  logic        out_io_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        out_halt;

  ram_io_responder #(.RAM_ADDR_WIDTH(RAW), .TX_DEPTH(TXD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_rw(in_rw), .in_addr(in_addr),
    .in_data(in_data), .out_data(out_data), .out_io_full(out_io_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .out_halt(out_halt)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] mem_m [int unsigned];
  logic [7:0] txq [$];
  logic       m_ovf, m_rx_full, m_halt, m_known;
  logic [7:0] m_rx_byte, m_out;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    if (m_known) chk("out_data", out_data, m_out);
    chk("io_full", {7'b0, out_io_full}, {7'b0, txq.size() >= TXD - 2});
    chk("tx_valid", {7'b0, tx_valid}, {7'b0, txq.size() != 0});
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    chk("rx_ready", {7'b0, rx_ready}, {7'b0, !m_rx_full});
    chk("halt", {7'b0, out_halt}, {7'b0, m_halt});
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic s_rst, input logic s_rdy, input logic s_rw,
                      input logic [31:0] a, input logic [7:0] d,
                      input logic txr, input logic rxv, input logic [7:0] rxd);
    logic io;
    logic [2:0] off;
    int unsigned idx;
    logic [7:0] st;
    rst = s_rst; rdy = s_rdy; in_rw = s_rw; in_addr = a; in_data = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    if (s_rst) begin
      txq.delete();
      m_ovf = 1'b0; m_rx_full = 1'b0; m_halt = 1'b0; m_out = 8'h00; m_known = 1'b1;
    end else if (s_rdy) begin
      io  = (a[17:16] == 2'b11);
      off = a[2:0];
      idx = a[RAW-1:0];
      st  = {5'b0, m_ovf, m_rx_full, txq.size() == TXD};
      if (!s_rw) begin
        m_known = 1'b1;
        if (io) m_out = (off == 3'd0) ? (m_rx_full ? m_rx_byte : 8'h00) :
                        (off == 3'd4) ? st : 8'h00;
        else if (mem_m.exists(idx)) m_out = mem_m[idx];
        else m_known = 1'b0;
      end
      if (txq.size() != 0 && txr) void'(txq.pop_front());
      if (io && s_rw && off == 3'd0) begin
        if (txq.size() < TXD) txq.push_back(d);
        else m_ovf = 1'b1;
      end
      if (rxv && !m_rx_full) begin
        m_rx_full = 1'b1; m_rx_byte = rxd;
      end else if (io && !s_rw && off == 3'd0 && m_rx_full) begin
        m_rx_full = 1'b0;
      end
      if (io && s_rw && off == 3'd4) m_halt = 1'b1;
      if (!io && s_rw) mem_m[idx] = d;
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic txr);
    step(1'b0, 1'b1, 1'b1, a, d, txr, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a, input logic txr);
    step(1'b0, 1'b1, 1'b0, a, 8'h00, txr, 1'b0, 8'h00);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    logic [31:0] a;
    int k;
    r = $urandom();
    if ($urandom_range(0, 9) < 4) begin
      k = $urandom_range(0, 35);
      a = (k < 32) ? 32'(k) : 32'(32'h100 + k - 32);
      a[17] = r[17];
      a[31:18] = r[31:18];
    end else begin
      a = r;
      a[17:16] = 2'b11;
      k = $urandom_range(0, 7);
      a[2:0] = (k < 4) ? 3'd0 : (k == 4) ? 3'd4 : r[2:0];
    end
    return a;
  endfunction

  logic [7:0] exp_tx [8];

  initial begin
    m_ovf = 0; m_rx_full = 0; m_halt = 0; m_known = 0; m_rx_byte = 0; m_out = 0;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 8'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 8'h0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_io_full", {7'b0, out_io_full}, 8'h00);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("rst_halt", {7'b0, out_halt}, 8'h00);

    // Initialize the RAM pool the random phase touches.
    for (int i = 0; i < 32; i++) wr(32'(i), 8'($urandom()), 1'b0);
    for (int i = 4; i < 16; i++) wr(32'(32'h100 + i), 8'($urandom()), 1'b0);

    // RAM stream
    wr(32'h100, 8'h11, 1'b0); wr(32'h101, 8'h22, 1'b0);
    wr(32'h102, 8'h33, 1'b0); wr(32'h103, 8'h44, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd(32'(32'h100 + i), 1'b0);
      chk("ram_stream", out_data, 8'(8'h11 * (i + 1)));
    end
    rd(32'hFFFC_0101, 1'b0);
    chk("ram_alias", out_data, 8'h22);

    // TX fill, overflow, drain
    for (int i = 1; i <= TXD; i++) begin
      wr(32'h30000, 8'(8'h40 + i), 1'b0);
      chk("io_full_fill", {7'b0, out_io_full}, {7'b0, i >= 6});
    end
    wr(32'h30000, 8'h49, 1'b0);
    rd(32'h30004, 1'b0);
    chk("status_full_ovf", out_data, 8'h05);
    for (int i = 0; i < TXD; i++) begin
      chk("drain_valid", {7'b0, tx_valid}, 8'h01);
      chk("drain_data", tx_data, 8'(8'h41 + i));
      rd(32'h0, 1'b1);
    end
    chk("drain_empty", {7'b0, tx_valid}, 8'h00);

    // Simultaneous push and pop while full
    for (int i = 0; i < TXD; i++) wr(32'h30000, 8'(8'h50 + i), 1'b0);
    wr(32'h30000, 8'h5A, 1'b1);
    rd(32'h30004, 1'b0);
    chk("status_pushpop", out_data, 8'h05);
    for (int i = 0; i < 7; i++) exp_tx[i] = 8'(8'h51 + i);
    exp_tx[7] = 8'h5A;
    for (int i = 0; i < TXD; i++) begin
      chk("pushpop_data", tx_data, exp_tx[i]);
      rd(32'h0, 1'b1);
    end
    chk("pushpop_empty", {7'b0, tx_valid}, 8'h00);

    // RX holding register
    step(1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 8'h7E);
    chk("rx_ready_low", {7'b0, rx_ready}, 8'h00);
    rd(32'h30000, 1'b0);
    chk("rx_read", out_data, 8'h7E);
    rd(32'h30000, 1'b0);
    chk("rx_read_empty", out_data, 8'h00);
    step(1'b0, 1'b1, 1'b0, 32'h30000, 8'h0, 1'b0, 1'b1, 8'h3C);
    chk("rx_coincident", {7'b0, rx_ready}, 8'h00);
    rd(32'h30000, 1'b0);
    chk("rx_coincident_byte", out_data, 8'h3C);

    // Halt and rdy gating
    wr(32'h30004, 8'h00, 1'b0);
    chk("halt_set", {7'b0, out_halt}, 8'h01);
    wr(32'h10, 8'hA5, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h10, 8'h99, 1'b0, 1'b0, 8'h0);
    rd(32'h10, 1'b0);
    chk("rdy_low_write", out_data, 8'hA5);

    // Reset mid-traffic
    for (int i = 0; i < 3; i++) wr(32'h30000, 8'(8'h60 + i), 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 8'h12);
    step(1'b1, 1'b1, 1'b1, 32'h30000, 8'h77, 1'b1, 1'b1, 8'h34);
    chk("mid_rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("mid_rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("mid_rst_halt", {7'b0, out_halt}, 8'h00);
    chk("mid_rst_out_data", out_data, 8'h00);
    rd(32'h30004, 1'b0);
    chk("mid_rst_status", out_data, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 85),
           1'($urandom_range(0, 1)), rand_addr(), 8'($urandom()),
           ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 25 : 70)),
           ($urandom_range(0, 99) < 30), 8'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
